// File: rtl/bus_port_pkg.sv
// Shared definitions for the bus output port: FSM state encoding and
// the pointer-width helper used to size FIFO pointers and occupancy.
package bus_port_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  function automatic int ptrWidth(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/bus_out_port_if.sv
// Datapath push side and bus handshake side of the output port; the port
// itself uses the master view, its environment the slave view.
interface bus_out_port_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] d;
  logic             wr;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic             ovf;
  logic             gnt;
  logic [WIDTH-1:0] q;
  logic             g_;
  logic             req;
  logic             ack;

  modport master (
    input  d, wr, gnt, ack,
    output full, empty, count, ovf, q, g_, req
  );

  modport slave (
    output d, wr, gnt, ack,
    input  full, empty, count, ovf, q, g_, req
  );
endinterface

// File: rtl/bus_out_fifo.sv
// Circular-buffer FIFO with registered occupancy, sticky overflow and a
// combinational head-word read port.
module bus_out_fifo
  import bus_port_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_i,
  input  logic [WIDTH-1:0]         d_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [ptrWidth(DEPTH):0] count_o,
  output logic                     ovf_o,
  output logic [WIDTH-1:0]         head_o
);
  localparam int PW = ptrWidth(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rdPtr_q, rdPtr_d;
  logic [PW-1:0]    wrPtr_q, wrPtr_d;
  logic [PW:0]      count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             doPush, doPop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign ovf_o   = ovf_q;
  assign head_o  = mem_q[rdPtr_q];

  // A push into a full FIFO still lands when a pop frees a slot on the same edge.
  assign doPop  = pop_i && !empty_o;
  assign doPush = wr_i && (!full_o || doPop);

  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    ovf_d   = ovf_q | (wr_i & ~doPush);
    if (doPush) wrPtr_d = wrPtr_q + 1'b1;
    if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
    case ({doPush, doPop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= d_i;
  end

endmodule

// File: rtl/bus_out_port.sv
// Handshaked tristate-driver output stage: queues datapath words and drives
// them onto the bus under grant, with a turnaround cycle after every transfer.
module bus_out_port
  import bus_port_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  bus_out_port_if.master bus
);
  localparam int PW = ptrWidth(DEPTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             gBar_q, req_q;
  logic             pop;
  logic             fifoEmpty, fifoFull, fifoOvf;
  logic [PW:0]      fifoCount;
  logic [WIDTH-1:0] head;

  bus_out_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_i    (bus.wr),
    .d_i     (bus.d),
    .pop_i   (pop),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifoCount),
    .ovf_o   (fifoOvf),
    .head_o  (head)
  );

  assign bus.full  = fifoFull;
  assign bus.empty = fifoEmpty;
  assign bus.count = fifoCount;
  assign bus.ovf   = fifoOvf;
  assign bus.q     = q_q;
  assign bus.g_    = gBar_q;
  assign bus.req   = req_q;

  // ack wins over a simultaneous grant drop so an acknowledged word is never resent.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifoEmpty && bus.gnt) begin
          q_d     = head;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (bus.ack) begin
          pop     = 1'b1;
          state_d = RELEASE;
        end else if (!bus.gnt) begin
          state_d = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Enable and strobe are registered from the next state so they switch cleanly together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      gBar_q  <= 1'b1;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      gBar_q  <= (state_d != DRIVE);
      req_q   <= (state_d == DRIVE);
    end
  end

endmodule
